// File: rtl/avalon_mm_cmd_queue_if.sv
// Signal bundle between a requester, the command queue and a downstream Avalon MM master.
// The slave modport is the queue's view; the master modport is the requester/master side.
interface avalon_mm_cmd_queue_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rnw;
    logic [WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;
    logic             rsp_valid;
    logic             rsp_rnw;
    logic [WIDTH-1:0] rsp_rdata;
    logic             start;
    logic             rnw;
    logic [WIDTH-1:0] address_to_access;
    logic [WIDTH-1:0] data_to_write;
    logic             done;
    logic [WIDTH-1:0] data_read;
    logic [CW-1:0]    fifo_count;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, done, data_read,
        output cmd_ready, rsp_valid, rsp_rnw, rsp_rdata, start, rnw,
        output address_to_access, data_to_write, fifo_count, busy
    );

    modport master (
        output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, done, data_read,
        input  cmd_ready, rsp_valid, rsp_rnw, rsp_rdata, start, rnw,
        input  address_to_access, data_to_write, fifo_count, busy
    );
endinterface

// File: rtl/avalon_mm_cmd_queue.sv
// Command queue in front of an Avalon MM master: buffers requests in a circular FIFO
// and issues them one at a time, returning one response pulse per completed command.
module avalon_mm_cmd_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic                  CLK,
    input logic                  RESET,
    avalon_mm_cmd_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] rnw_mem;
    logic [WIDTH-1:0] addr_mem  [DEPTH];
    logic [WIDTH-1:0] wdata_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             cmd_rnw_q;
    logic [WIDTH-1:0] cmd_addr_q, cmd_wdata_q;
    logic             rsp_valid_q, rsp_rnw_q;
    logic [WIDTH-1:0] rsp_rdata_q;
    logic             not_full, push, pop, complete;

    assign not_full = (count_q != CW'(DEPTH));
    assign push     = bus.cmd_valid & not_full;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.done) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage needs no reset; the pointers define which entries are live.
    // Write data is zeroed here so reads never present stale data downstream.
    always_ff @(posedge CLK) begin
        if (push) begin
            rnw_mem[wr_ptr_q]   <= bus.cmd_rnw;
            addr_mem[wr_ptr_q]  <= bus.cmd_addr;
            wdata_mem[wr_ptr_q] <= bus.cmd_rnw ? '0 : bus.cmd_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_rnw_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rnw_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= complete;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                cmd_rnw_q   <= rnw_mem[rd_ptr_q];
                cmd_addr_q  <= addr_mem[rd_ptr_q];
                cmd_wdata_q <= wdata_mem[rd_ptr_q];
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (complete) begin
                rsp_rnw_q   <= cmd_rnw_q;
                rsp_rdata_q <= cmd_rnw_q ? bus.data_read : '0;
            end
        end
    end

    assign bus.cmd_ready         = not_full;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_rnw           = rsp_rnw_q;
    assign bus.rsp_rdata         = rsp_rdata_q;
    assign bus.start             = (state_q == S_ISSUE);
    assign bus.rnw               = cmd_rnw_q;
    assign bus.address_to_access = cmd_addr_q;
    assign bus.data_to_write     = cmd_wdata_q;
    assign bus.fifo_count        = count_q;
    assign bus.busy              = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_avalon_mm_cmd_queue.sv
// Directed bench for avalon_mm_cmd_queue (WIDTH=32, DEPTH=4); a small negedge monitor
// logs start/response events for ordering and spacing checks.
module tb_avalon_mm_cmd_queue;
    logic CLK;
    logic RESET;

    avalon_mm_cmd_queue_if #(.WIDTH(32), .DEPTH(4)) bus ();

    avalon_mm_cmd_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int          ncyc = 0, start_cnt = 0, rsp_cnt = 0, done_cnt = 0, start_after_done = 0;
    bit          done_prev = 1'b0;
    int          start_cyc[$];
    logic [31:0] start_addr[$];
    logic [31:0] rsp_data[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        ncyc++;
        if (bus.start === 1'b1) begin
            start_cnt++;
            start_cyc.push_back(ncyc);
            start_addr.push_back(bus.address_to_access);
            if (done_prev) start_after_done++;
        end
        if (bus.rsp_valid === 1'b1) begin
            rsp_cnt++;
            rsp_data.push_back(bus.rsp_rdata);
        end
        done_prev = (bus.done === 1'b1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Answer each issued command with done one cycle after its start pulse.
    task automatic serve(input int n, input logic [31:0] base);
        int served = 0;
        for (int c = 0; c < 400 && served < n; c++) begin
            if (start_cnt > done_cnt && bus.start !== 1'b1) begin
                bus.done      = 1'b1;
                bus.data_read = base + 32'(served);
                tick();
                bus.done = 1'b0;
                done_cnt++;
                served++;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h99;
        tick();
        tick();
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %h want 1", bus.cmd_ready); end
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %h want 0", bus.fifo_count); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
        vectors++; if (bus.start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %h want 0", bus.start); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %h want 0", bus.rsp_valid); end
        vectors++; if (bus.address_to_access !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", bus.address_to_access); end
        RESET = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_single_write();
        int s0 = start_cnt, r0 = rsp_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b0; bus.cmd_addr = 32'h10; bus.cmd_wdata = 32'hDEADBEEF;
        tick();
        bus.cmd_valid = 1'b0;
        vectors++; if (bus.fifo_count !== 3'd1) begin miscompares++; $display("FAIL wr_count_push: got %h want 1", bus.fifo_count); end
        vectors++; if (bus.start !== 1'b0) begin miscompares++; $display("FAIL wr_start_early: got %h want 0", bus.start); end
        tick();
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL wr_start: got %h want 1", bus.start); end
        vectors++; if (bus.address_to_access !== 32'h10) begin miscompares++; $display("FAIL wr_addr: got %h want 10", bus.address_to_access); end
        vectors++; if (bus.data_to_write !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_data: got %h want deadbeef", bus.data_to_write); end
        vectors++; if (bus.rnw !== 1'b0) begin miscompares++; $display("FAIL wr_rnw: got %h want 0", bus.rnw); end
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL wr_count_pop: got %h want 0", bus.fifo_count); end
        tick();
        vectors++; if (bus.start !== 1'b0) begin miscompares++; $display("FAIL wr_start_once: got %h want 0", bus.start); end
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        done_cnt++;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_valid: got %h want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_rnw !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_rnw: got %h want 0", bus.rsp_rnw); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL wr_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        vectors++; if (bus.address_to_access !== 32'h10) begin miscompares++; $display("FAIL wr_addr_hold: got %h want 10", bus.address_to_access); end
        tick();
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_pulse: got %h want 0", bus.rsp_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_end: got %h want 0", bus.busy); end
        vectors++; if (start_cnt - s0 !== 1) begin miscompares++; $display("FAIL wr_start_count: got %0d want 1", start_cnt - s0); end
        vectors++; if (rsp_cnt - r0 !== 1) begin miscompares++; $display("FAIL wr_rsp_count: got %0d want 1", rsp_cnt - r0); end
    endtask

    task automatic test_single_read();
        int r0 = rsp_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b1; bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'hFFFFFFFF;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL rd_start: got %h want 1", bus.start); end
        vectors++; if (bus.rnw !== 1'b1) begin miscompares++; $display("FAIL rd_rnw: got %h want 1", bus.rnw); end
        vectors++; if (bus.address_to_access !== 32'h20) begin miscompares++; $display("FAIL rd_addr: got %h want 20", bus.address_to_access); end
        vectors++; if (bus.data_to_write !== 32'h0) begin miscompares++; $display("FAIL rd_wdata_zero: got %h want 0", bus.data_to_write); end
        tick();
        bus.done = 1'b1;
        bus.data_read = 32'h12345678;
        tick();
        bus.done = 1'b0;
        bus.data_read = 32'hAAAA5555;
        done_cnt++;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rd_rsp_valid: got %h want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'h12345678) begin miscompares++; $display("FAIL rd_rsp_rdata: got %h want 12345678", bus.rsp_rdata); end
        vectors++; if (bus.rsp_rnw !== 1'b1) begin miscompares++; $display("FAIL rd_rsp_rnw: got %h want 1", bus.rsp_rnw); end
        repeat (3) tick();
        vectors++; if (rsp_cnt - r0 !== 1) begin miscompares++; $display("FAIL rd_rsp_count: got %0d want 1", rsp_cnt - r0); end
        vectors++; if (bus.rsp_rdata !== 32'h12345678) begin miscompares++; $display("FAIL rd_rdata_hold: got %h want 12345678", bus.rsp_rdata); end
    endtask

    task automatic test_full();
        int s0 = start_cnt, r0 = rsp_cnt;
        start_addr.delete();
        bus.done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b0;
            bus.cmd_addr = 32'h100 + 32'(i); bus.cmd_wdata = 32'(i + 1);
            tick();
        end
        bus.cmd_addr = 32'h105; bus.cmd_wdata = 32'd6;
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %h want 0", bus.cmd_ready); end
        vectors++; if (bus.fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %h want 4", bus.fifo_count); end
        vectors++; if (start_cnt - s0 !== 1) begin miscompares++; $display("FAIL full_one_issued: got %0d want 1", start_cnt - s0); end
        repeat (3) tick();
        vectors++; if (bus.fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_no_overwrite: got %h want 4", bus.fifo_count); end
        vectors++; if (bus.address_to_access !== 32'h100) begin miscompares++; $display("FAIL full_addr_hold: got %h want 100", bus.address_to_access); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        done_cnt++;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL full_rsp1: got %h want 1", bus.rsp_valid); end
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_still: got %h want 0", bus.cmd_ready); end
        tick();
        vectors++; if (bus.fifo_count !== 3'd3) begin miscompares++; $display("FAIL full_pop_count: got %h want 3", bus.fifo_count); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_free: got %h want 1", bus.cmd_ready); end
        vectors++; if (bus.address_to_access !== 32'h101) begin miscompares++; $display("FAIL full_addr2: got %h want 101", bus.address_to_access); end
        tick();
        bus.cmd_valid = 1'b0;
        vectors++; if (bus.fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_sixth_push: got %h want 4", bus.fifo_count); end
        serve(5, 32'h0);
        repeat (2) tick();
        vectors++; if (rsp_cnt - r0 !== 6) begin miscompares++; $display("FAIL full_rsp_count: got %0d want 6", rsp_cnt - r0); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL full_drained: got %h want 0", bus.busy); end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (start_addr[i] !== 32'h100 + 32'(i)) begin
                miscompares++; $display("FAIL full_order[%0d]: got %h want %h", i, start_addr[i], 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        start_cyc.delete(); start_addr.delete(); rsp_data.delete();
        start_after_done = 0;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b1; bus.cmd_addr = 32'h40 + 32'(4 * i); bus.cmd_wdata = 32'h0;
            tick();
        end
        bus.cmd_valid = 1'b0;
        serve(3, 32'hA0);
        repeat (2) tick();
        vectors++; if (rsp_data.size() !== 3) begin miscompares++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp_data.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rsp_data[i] !== 32'hA0 + 32'(i)) begin
                miscompares++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rsp_data[i], 32'hA0 + 32'(i));
            end
            vectors++;
            if (start_addr[i] !== 32'h40 + 32'(4 * i)) begin
                miscompares++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, start_addr[i], 32'h40 + 32'(4 * i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (start_cyc[i + 1] - start_cyc[i] < 3) begin
                miscompares++; $display("FAIL b2b_gap[%0d]: got %0d want >=3", i, start_cyc[i + 1] - start_cyc[i]);
            end
        end
        vectors++; if (start_after_done !== 0) begin miscompares++; $display("FAIL b2b_start_after_done: got %0d want 0", start_after_done); end
    endtask

    task automatic test_reset_mid();
        int s0 = start_cnt, r0 = rsp_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b0; bus.cmd_addr = 32'h200 + 32'(i); bus.cmd_wdata = 32'h77;
            tick();
        end
        bus.cmd_valid = 1'b0;
        vectors++; if (bus.fifo_count !== 3'd2) begin miscompares++; $display("FAIL rst_mid_queued: got %h want 2", bus.fifo_count); end
        vectors++; if (start_cnt - s0 !== 1) begin miscompares++; $display("FAIL rst_mid_issued: got %0d want 1", start_cnt - s0); end
        #2 RESET = 1'b1;
        #1;
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL rst_mid_count: got %h want 0", bus.fifo_count); end
        vectors++; if (bus.address_to_access !== 32'h0) begin miscompares++; $display("FAIL rst_mid_addr: got %h want 0", bus.address_to_access); end
        vectors++; if (bus.data_to_write !== 32'h0) begin miscompares++; $display("FAIL rst_mid_wdata: got %h want 0", bus.data_to_write); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mid_rdata: got %h want 0", bus.rsp_rdata); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %h want 0", bus.busy); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %h want 1", bus.cmd_ready); end
        tick();
        tick();
        RESET = 1'b0;
        done_cnt = start_cnt;
        vectors++; if (rsp_cnt !== r0) begin miscompares++; $display("FAIL rst_mid_no_rsp: got %0d want %0d", rsp_cnt, r0); end
        bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b1; bus.cmd_addr = 32'h80; bus.cmd_wdata = 32'h0;
        tick();
        bus.cmd_valid = 1'b0;
        serve(1, 32'h5A5A0000);
        tick();
        vectors++; if (rsp_cnt - r0 !== 1) begin miscompares++; $display("FAIL rst_mid_new_rsp: got %0d want 1", rsp_cnt - r0); end
        vectors++; if (bus.rsp_rdata !== 32'h5A5A0000) begin miscompares++; $display("FAIL rst_mid_new_rdata: got %h want 5a5a0000", bus.rsp_rdata); end
        vectors++; if (bus.rsp_rnw !== 1'b1) begin miscompares++; $display("FAIL rst_mid_new_rnw: got %h want 1", bus.rsp_rnw); end
        vectors++; if (start_cnt - s0 !== 2) begin miscompares++; $display("FAIL rst_mid_discard: got %0d want 2", start_cnt - s0); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle: got %h want 0", bus.busy); end
    endtask

    task automatic test_stray_done();
        int s0 = start_cnt, r0 = rsp_cnt;
        bus.done = 1'b1;
        bus.data_read = 32'hDEAD0000;
        tick();
        tick();
        bus.done = 1'b0;
        tick();
        vectors++; if (rsp_cnt !== r0) begin miscompares++; $display("FAIL stray_rsp: got %0d want %0d", rsp_cnt, r0); end
        vectors++; if (start_cnt !== s0) begin miscompares++; $display("FAIL stray_start: got %0d want %0d", start_cnt, s0); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL stray_busy: got %h want 0", bus.busy); end
        vectors++; if (bus.rsp_rdata !== 32'h5A5A0000) begin miscompares++; $display("FAIL stray_rdata: got %h want 5a5a0000", bus.rsp_rdata); end
    endtask

    initial begin
        RESET = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.done = 1'b0; bus.data_read = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_stray_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/avalon_mm_cmd_queue.md
AVALON_MM_CMD_QUEUE -- requirements
Module: avalon_mm_cmd_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1  requester presents a command.
REQ-006 SHALL have port cmd_ready  out  1  queue accepts the command this cycle; equals not-full.
REQ-007 SHALL have port cmd_rnw  in  1  1 = read, 0 = write.
REQ-008 SHALL have port cmd_addr  in  WIDTH  target address.
REQ-009 SHALL have port cmd_wdata  in  WIDTH  write data; ignored for reads.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle pulse per completed command.
REQ-011 SHALL have port rsp_rnw  out  1  type of the completed command.
REQ-012 SHALL have port rsp_rdata  out  WIDTH  read data captured at completion; 0 for writes.
REQ-013 SHALL have port start  out  1  one-cycle pulse to the downstream Avalon MM master.
REQ-014 SHALL have port rnw  out  1  command type to the master.
REQ-015 SHALL have port address_to_access  out  WIDTH  address to the master.
REQ-016 SHALL have port data_to_write  out  WIDTH  write data to the master.
REQ-017 SHALL have port done  in  1  master completion strobe, high for one cycle.
REQ-018 SHALL have port data_read  in  WIDTH  master read data, valid while done=1.
REQ-019 SHALL have port fifo_count  out  $clog2(DEPTH)+1  number of queued, not-yet-issued commands.
REQ-020 SHALL have port busy  out  1  high when FSM is not in S_IDLE or fifo_count != 0.

Function
REQ-021 SHALL push {rnw, addr, wdata} into a circular FIFO when cmd_valid and cmd_ready are both high.
REQ-022 SHALL hold cmd_ready low when fifo_count == DEPTH; cmd_valid while full SHALL be ignored, with no overwrite.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; fifo_count SHALL never exceed DEPTH or go below 0.
REQ-024 SHALL implement FSM states S_IDLE, S_ISSUE and S_WAIT.
REQ-025 S_IDLE SHALL pop the FIFO head into the command register and go to S_ISSUE when fifo_count != 0; otherwise it SHALL stay in S_IDLE.
REQ-026 S_ISSUE SHALL drive start=1 for exactly one cycle and then go to S_WAIT unconditionally.
REQ-027 S_WAIT SHALL hold start=0 and wait for done; on done=1 it SHALL capture data_read (reads only), pulse rsp_valid on the next cycle, and go to S_IDLE.
REQ-028 rnw, address_to_access and data_to_write SHALL be driven from the command register, stable from S_ISSUE until the cycle after done, because the master samples them in its wait and done states.
REQ-029 Issue latency SHALL be as follows: a push into an empty queue while in S_IDLE gives start two cycles later (push edge, pop edge).
REQ-030 At most one command SHALL be outstanding at the master; the next start SHALL come no earlier than one cycle after done, when the master has returned to idle.
REQ-031 A simultaneous push and pop SHALL be legal and SHALL leave fifo_count unchanged.
REQ-032 done asserted outside S_WAIT SHALL be ignored, producing no rsp_valid and no state change.
REQ-033 rsp_rnw and rsp_rdata SHALL hold their values until the next completion.
REQ-034 data_to_write SHALL be 0 for read commands.

Reset
REQ-035 On RESET=1, the block SHALL immediately enter S_IDLE, empty the FIFO (pointers and count 0) and clear all outputs to 0, except cmd_ready, which SHALL be 1.
REQ-036 A reset during S_WAIT SHALL abandon the in-flight command with no rsp_valid; queued commands SHALL be discarded.
REQ-037 No push SHALL be accepted on the first rising edge after RESET deasserts if RESET is still high at that edge.

Verification
REQ-038 Single write: push {rnw=0, addr=0x10, wdata=0xDEADBEEF} into an empty queue, done after 3 cycles -> start pulses once with address_to_access=0x10 and data_to_write=0xDEADBEEF; rsp_valid=1 with rsp_rnw=0 and rsp_rdata=0.
REQ-039 Single read: push {rnw=1, addr=0x20}, data_read=0x12345678 with done -> rsp_rdata=0x12345678, rsp_rnw=1, exactly one rsp_valid.
REQ-040 Full: with done held low, push 6 commands at DEPTH=4 -> one command is issued and 4 are queued; cmd_ready=0 with fifo_count=4; the 6th push is stalled and accepted only after the first completion.
REQ-041 Back-to-back: queue 3 reads, done returned 1 cycle after each start -> start pulses are at least 3 cycles apart, responses come in push order, and start is never high in the cycle after done.
REQ-042 Reset mid-transfer: assert RESET while in S_WAIT with 2 commands queued -> outputs are 0, fifo_count=0 and no rsp_valid; after release, a new read completes normally.
REQ-043 Stray done: pulse done while in S_IDLE -> no rsp_valid and no state change.
